pe_frame_controller: RTL and testbench

- Initiator for the background-removal processing element (PE): drives its Start_Sum / Start_BgRemoval / Ack handshake and its packed pixel vectors.
- Pass 1 streams every tile of a frame from pixel memory through the PE sum operation, accumulates the frame sums and derives the expected background colour by averaging.
- Pass 2 streams the frame again through the PE background-replace operation and writes the returned pixels to the output memory.
- Sits between the frame buffers and one PE instance.

---
 rtl/pe_frame_controller.sv | 244 ++++++++++++++++++++++++
 tb/tb_pe_frame_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_frame_controller.sv
// Two-pass frame controller for the background-removal PE: sums every tile to find the
// background colour, then streams the frame back through the PE. Build option: AVG_ROUND_EN.
module pe_frame_controller #(
    parameter int unsigned NUM_PIXELS = 1,
    parameter int unsigned LOG2_FRAME = 4,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    output logic                    Busy,
    output logic                    Done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [7:0]              rd_r,
    input  logic [7:0]              rd_g,
    input  logic [7:0]              rd_b,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_r,
    output logic [7:0]              wr_g,
    output logic [7:0]              wr_b,
    output logic                    pe_start_sum,
    output logic                    pe_start_bg,
    output logic                    pe_ack,
    output logic [8*NUM_PIXELS:0]   pe_red,
    output logic [8*NUM_PIXELS:0]   pe_green,
    output logic [8*NUM_PIXELS:0]   pe_blue,
    input  logic                    pe_qi,
    input  logic                    pe_qsd,
    input  logic                    pe_qbgd,
    input  logic [8*NUM_PIXELS:0]   pe_red_sum,
    input  logic [8*NUM_PIXELS:0]   pe_green_sum,
    input  logic [8*NUM_PIXELS:0]   pe_blue_sum,
    input  logic [8*NUM_PIXELS:0]   pe_red_out,
    input  logic [8*NUM_PIXELS:0]   pe_green_out,
    input  logic [8*NUM_PIXELS:0]   pe_blue_out,
    output logic [8:0]              red_exp,
    output logic [8:0]              green_exp,
    output logic [8:0]              blue_exp
);

    localparam int unsigned PV  = 8 * NUM_PIXELS;
    localparam int unsigned SW  = 8 + $clog2(NUM_PIXELS);
    localparam int unsigned AW  = 8 + LOG2_FRAME;
    localparam int unsigned NT  = (1 << LOG2_FRAME) / NUM_PIXELS;
    localparam int unsigned TW  = LOG2_FRAME + 1;
    localparam int unsigned CW  = $clog2(NUM_PIXELS + 1);
    localparam int unsigned RND = (LOG2_FRAME > 0) ? (1 << (LOG2_FRAME - 1)) : 0;

    typedef enum logic [3:0] {
        StIdle, StSLoad, StSGo, StSWait, StSRel, StSAvg,
        StBLoad, StBGo, StBWait, StBWrite, StBRel, StDone
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tile_q;
    logic [PV-1:0]   pix_r_q, pix_g_q, pix_b_q;
    logic [PV-1:0]   out_r_q, out_g_q, out_b_q;
    logic [AW-1:0]   acc_r_q, acc_g_q, acc_b_q;

    assign pe_red   = {1'b0, pix_r_q};
    assign pe_green = {1'b0, pix_g_q};
    assign pe_blue  = {1'b0, pix_b_q};

    logic unused_in;
    assign unused_in = ^{pe_red_sum[PV:SW], pe_green_sum[PV:SW], pe_blue_sum[PV:SW],
                         pe_red_out[PV], pe_green_out[PV], pe_blue_out[PV]};

    function automatic logic [8:0] frame_avg(input logic [AW-1:0] acc);
        logic [AW:0] s;
`ifdef AVG_ROUND_EN
        s = ({1'b0, acc} + (AW+1)'(RND)) >> LOG2_FRAME;
`else
        s = {1'b0, acc} >> LOG2_FRAME;
`endif
        frame_avg = (|s[AW:8]) ? 9'd255 : {1'b0, s[7:0]};
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tile_q       <= '0;
            pix_r_q      <= '0;
            pix_g_q      <= '0;
            pix_b_q      <= '0;
            out_r_q      <= '0;
            out_g_q      <= '0;
            out_b_q      <= '0;
            acc_r_q      <= '0;
            acc_g_q      <= '0;
            acc_b_q      <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_r         <= '0;
            wr_g         <= '0;
            wr_b         <= '0;
            pe_start_sum <= 1'b0;
            pe_start_bg  <= 1'b0;
            pe_ack       <= 1'b0;
            red_exp      <= '0;
            green_exp    <= '0;
            blue_exp     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        acc_r_q   <= '0;
                        acc_g_q   <= '0;
                        acc_b_q   <= '0;
                        red_exp   <= '0;
                        green_exp <= '0;
                        blue_exp  <= '0;
                        tile_q    <= '0;
                        cnt_q     <= '0;
                        rd_en     <= 1'b1;
                        rd_addr   <= '0;
                        Busy      <= 1'b1;
                        state_q   <= StSLoad;
                    end
                end
                StSLoad, StBLoad: begin
                    // Data for the read issued at cnt-1 is on the bus now.
                    if (cnt_q != '0) begin
                        pix_r_q[8*(int'(cnt_q)-1) +: 8] <= rd_r;
                        pix_g_q[8*(int'(cnt_q)-1) +: 8] <= rd_g;
                        pix_b_q[8*(int'(cnt_q)-1) +: 8] <= rd_b;
                    end
                    if (cnt_q == CW'(NUM_PIXELS)) begin
                        cnt_q <= '0;
                        if (state_q == StSLoad) begin
                            pe_start_sum <= 1'b1;
                            state_q      <= StSGo;
                        end else begin
                            pe_start_bg <= 1'b1;
                            state_q     <= StBGo;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(NUM_PIXELS - 1)) begin
                            rd_en <= 1'b0;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                end
                StSGo: begin
                    pe_start_sum <= 1'b0;
                    state_q      <= StSWait;
                end
                StSWait: begin
                    if (pe_qsd) begin
                        acc_r_q <= acc_r_q + AW'(pe_red_sum[SW-1:0]);
                        acc_g_q <= acc_g_q + AW'(pe_green_sum[SW-1:0]);
                        acc_b_q <= acc_b_q + AW'(pe_blue_sum[SW-1:0]);
                        pe_ack  <= 1'b1;
                        state_q <= StSRel;
                    end
                end
                StSRel: begin
                    pe_ack <= 1'b0;
                    if (pe_qi) begin
                        if (tile_q == TW'(NT - 1)) begin
                            state_q <= StSAvg;
                        end else begin
                            tile_q  <= tile_q + 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                            state_q <= StSLoad;
                        end
                    end
                end
                StSAvg: begin
                    red_exp   <= frame_avg(acc_r_q);
                    green_exp <= frame_avg(acc_g_q);
                    blue_exp  <= frame_avg(acc_b_q);
                    tile_q    <= '0;
                    rd_en     <= 1'b1;
                    rd_addr   <= '0;
                    state_q   <= StBLoad;
                end
                StBGo: begin
                    pe_start_bg <= 1'b0;
                    state_q     <= StBWait;
                end
                StBWait: begin
                    if (pe_qbgd) begin
                        out_r_q <= pe_red_out[PV-1:0];
                        out_g_q <= pe_green_out[PV-1:0];
                        out_b_q <= pe_blue_out[PV-1:0];
                        wr_r    <= pe_red_out[7:0];
                        wr_g    <= pe_green_out[7:0];
                        wr_b    <= pe_blue_out[7:0];
                        wr_en   <= 1'b1;
                        wr_addr <= (tile_q == '0) ? '0 : wr_addr + 1'b1;
                        pe_ack  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StBWrite;
                    end
                end
                StBWrite: begin
                    pe_ack <= 1'b0;
                    if (cnt_q == CW'(NUM_PIXELS - 1)) begin
                        wr_en   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StBRel;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        wr_addr <= wr_addr + 1'b1;
                        wr_r    <= out_r_q[8*(int'(cnt_q)+1) +: 8];
                        wr_g    <= out_g_q[8*(int'(cnt_q)+1) +: 8];
                        wr_b    <= out_b_q[8*(int'(cnt_q)+1) +: 8];
                    end
                end
                StBRel: begin
                    if (pe_qi) begin
                        if (tile_q == TW'(NT - 1)) begin
                            Done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            tile_q  <= tile_q + 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= rd_addr + 1'b1;
                            state_q <= StBLoad;
                        end
                    end
                end
                StDone: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_frame_controller.sv
// Bench for pe_frame_controller: pixel memory, behavioural PE and a table of whole-frame vectors.
module tb_pe_frame_controller;

    localparam int NP  = 2;
    localparam int LF  = 2;
    localparam int AWD = 16;
    localparam int PW  = 8 * NP + 1;
    localparam int THR = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [AWD-1:0] rd_addr, wr_addr;
    logic [7:0] rd_r = '0, rd_g = '0, rd_b = '0;
    logic [7:0] wr_r, wr_g, wr_b;
    logic pe_start_sum, pe_start_bg, pe_ack;
    logic [PW-1:0] pe_red, pe_green, pe_blue;
    logic m_qi, m_qsd, m_qbgd;
    logic [PW-1:0] m_sum_r, m_sum_g, m_sum_b, m_out_r, m_out_g, m_out_b;
    logic [8:0] red_exp, green_exp, blue_exp;

    always #5 clk = ~clk;

    pe_frame_controller #(.NUM_PIXELS(NP), .LOG2_FRAME(LF), .ADDR_W(AWD)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Busy(busy), .Done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .pe_start_sum(pe_start_sum), .pe_start_bg(pe_start_bg), .pe_ack(pe_ack),
        .pe_red(pe_red), .pe_green(pe_green), .pe_blue(pe_blue),
        .pe_qi(m_qi), .pe_qsd(m_qsd), .pe_qbgd(m_qbgd),
        .pe_red_sum(m_sum_r), .pe_green_sum(m_sum_g), .pe_blue_sum(m_sum_b),
        .pe_red_out(m_out_r), .pe_green_out(m_out_g), .pe_blue_out(m_out_b),
        .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Pixel memory: one-cycle read latency.
    logic [7:0] mem_r[4], mem_g[4], mem_b[4];
    always @(posedge clk) begin
        if (rd_en) begin
            rd_r <= mem_r[rd_addr[1:0]];
            rd_g <= mem_g[rd_addr[1:0]];
            rd_b <= mem_b[rd_addr[1:0]];
        end
    end

    // Behavioural PE with programmable done latency and post-ack idle hold.
    int sum_delay = 0;
    int qi_hold = 0;
    logic pend, pend_bg, rel;
    int cd, rcd;
    always @(posedge clk or negedge rst_n) begin : pe_model
        int sr, sg, sb, d;
        logic [7:0] pr, pg, pb;
        if (!rst_n) begin
            m_qi <= 1'b1; m_qsd <= 1'b0; m_qbgd <= 1'b0;
            pend <= 1'b0; pend_bg <= 1'b0; rel <= 1'b0; cd <= 0; rcd <= 0;
            m_sum_r <= '0; m_sum_g <= '0; m_sum_b <= '0;
            m_out_r <= '0; m_out_g <= '0; m_out_b <= '0;
        end else begin
            if (pe_start_sum || pe_start_bg) begin
                sr = 0; sg = 0; sb = 0;
                for (int j = 0; j < NP; j++) begin
                    pr = pe_red[8*j +: 8]; pg = pe_green[8*j +: 8]; pb = pe_blue[8*j +: 8];
                    sr += int'(pr); sg += int'(pg); sb += int'(pb);
                    d = absdiff(int'(pr), int'(red_exp)) + absdiff(int'(pg), int'(green_exp))
                        + absdiff(int'(pb), int'(blue_exp));
                    if (d <= THR) begin
                        m_out_r[8*j +: 8] <= 8'd0;
                        m_out_g[8*j +: 8] <= 8'd255;
                        m_out_b[8*j +: 8] <= 8'd0;
                    end else begin
                        m_out_r[8*j +: 8] <= pr;
                        m_out_g[8*j +: 8] <= pg;
                        m_out_b[8*j +: 8] <= pb;
                    end
                end
                m_sum_r <= PW'(sr); m_sum_g <= PW'(sg); m_sum_b <= PW'(sb);
                m_qi <= 1'b0; pend <= 1'b1; pend_bg <= pe_start_bg; cd <= sum_delay;
            end else if (pend) begin
                if (cd == 0) begin
                    pend <= 1'b0;
                    if (pend_bg) m_qbgd <= 1'b1;
                    else m_qsd <= 1'b1;
                end else begin
                    cd <= cd - 1;
                end
            end
            if (pe_ack) begin
                m_qsd <= 1'b0; m_qbgd <= 1'b0; rel <= 1'b1; rcd <= qi_hold;
            end else if (rel) begin
                if (rcd == 0) begin
                    rel <= 1'b0; m_qi <= 1'b1;
                end else begin
                    rcd <= rcd - 1;
                end
            end
        end
    end

    // Protocol monitors and write log, sampled away from the active edge.
    logic ack_prev = 1'b0;
    int done_cnt = 0;
    int wcnt = 0;
    logic [31:0] wlog[8];
    logic seen_first = 1'b0;
    logic [PW-1:0] tile0_r;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pe_start_sum || pe_start_bg) check("start_needs_qi", 64'(m_qi), 64'd1);
            if (pe_start_sum || pe_start_bg || pe_ack)
                check("cmd_exclusive", 64'(int'(pe_start_sum) + int'(pe_start_bg)
                      + int'(pe_ack)), 64'd1);
            if (pe_ack) check("ack_one_cycle", 64'(ack_prev), 64'd0);
            if (done) done_cnt++;
            if (wr_en && wcnt < 8) begin
                wlog[wcnt] = {wr_addr[7:0], wr_r, wr_g, wr_b};
                wcnt++;
            end
            if (pe_start_sum && !seen_first) begin
                tile0_r = pe_red;
                seen_first = 1'b1;
            end
        end
        ack_prev = pe_ack;
    end

    typedef struct {
        logic [3:0][7:0] r, g, b;
        int sdly, hold;
        logic [23:0] exp_t, exp_rnd;
    } vec_t;
    vec_t vecs[5];

    task automatic check_reset();
        check("reset_ctl", 64'({busy, done, rd_en, wr_en, pe_start_sum, pe_start_bg, pe_ack}), 0);
        check("reset_addr", 64'({rd_addr, wr_addr}), 0);
        check("reset_wdata", 64'({wr_r, wr_g, wr_b}), 0);
        check("reset_pe_vec", 64'({pe_red, pe_green, pe_blue}), 0);
        check("reset_exp", 64'({red_exp, green_exp, blue_exp}), 0);
    endtask

    task automatic load_frame(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            mem_r[i] = v.r[i]; mem_g[i] = v.g[i]; mem_b[i] = v.b[i];
        end
        sum_delay = v.sdly;
        qi_hold = v.hold;
        wcnt = 0; done_cnt = 0; seen_first = 1'b0;
        for (int i = 0; i < 8; i++) wlog[i] = '0;
    endtask

    task automatic run_frame(input int vi, input int extra_start);
        vec_t v;
        logic [23:0] e;
        logic [31:0] expw;
        int cyc, d;
        bit done_seen;
        v = vecs[vi];
`ifdef AVG_ROUND_EN
        e = v.exp_rnd;
`else
        e = v.exp_t;
`endif
        load_frame(v);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_start);
            if (done) done_seen = 1'b1;
        end
        start = 1'b0;
        check("done_timeout", 64'(done_seen), 64'd1);
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("exp_colour", 64'({red_exp, green_exp, blue_exp}),
              64'({1'b0, e[23:16], 1'b0, e[15:8], 1'b0, e[7:0]}));
        check("tile0_pe_red", 64'(tile0_r), 64'({1'b0, v.r[1], v.r[0]}));
        check("write_count", 64'(wcnt), 64'd4);
        for (int i = 0; i < 4; i++) begin
            d = absdiff(int'(v.r[i]), int'(e[23:16])) + absdiff(int'(v.g[i]), int'(e[15:8]))
                + absdiff(int'(v.b[i]), int'(e[7:0]));
            expw = (d <= THR) ? {8'(i), 8'd0, 8'd255, 8'd0} : {8'(i), v.r[i], v.g[i], v.b[i]};
            check("write_pixel", 64'(wlog[i]), 64'(expw));
        end
    endtask

    initial begin : main
        int cyc;
        vecs[0] = '{r: {8'd11, 8'd11, 8'd11, 8'd10}, g: '0, b: '0, sdly: 0, hold: 0,
                    exp_t: 24'h0a0000, exp_rnd: 24'h0b0000};
        vecs[1] = '{r: {8'd10, 8'd7, 8'd4, 8'd1}, g: {8'd11, 8'd8, 8'd5, 8'd2},
                    b: {8'd12, 8'd9, 8'd6, 8'd3}, sdly: 1, hold: 1,
                    exp_t: 24'h050607, exp_rnd: 24'h060708};
        vecs[2] = '{r: {4{8'd200}}, g: {4{8'd100}}, b: {4{8'd50}}, sdly: 20, hold: 5,
                    exp_t: 24'hc86432, exp_rnd: 24'hc86432};
        vecs[3] = '{r: {4{8'd255}}, g: {4{8'd255}}, b: {4{8'd255}}, sdly: 3, hold: 2,
                    exp_t: 24'hffffff, exp_rnd: 24'hffffff};
        vecs[4] = '{r: {8'd3, 8'd0, 8'd0, 8'd0}, g: {8'd3, 8'd0, 8'd0, 8'd0},
                    b: {8'd3, 8'd0, 8'd0, 8'd0}, sdly: 0, hold: 3,
                    exp_t: 24'h000000, exp_rnd: 24'h010101};
        for (int i = 0; i < 4; i++) begin
            mem_r[i] = '0; mem_g[i] = '0; mem_b[i] = '0;
        end

        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(i, 0);

        // Start re-pulsed while pass 1 is running must not disturb the frame.
        run_frame(1, 5);

        // Reset in pass 2 aborts at once; the next frame must still complete.
        load_frame(vecs[0]);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!wr_en && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_pass2", 64'(wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
